// File: rtl/writeback_stage_pkg.sv
// Shared MEM/WB definitions: word layout, halt encoding, bubble value and the
// writeback state enum.
package writeback_stage_pkg;

  localparam int WORD_W        = 36;
  localparam int WB_DATA_W     = 24;
  localparam int WB_REG_ADDR_W = 4;

  localparam int OP_TYPE_MSB    = 35;
  localparam int OP_TYPE_LSB    = 34;
  localparam int OP_CODE_MSB    = 33;
  localparam int OP_CODE_LSB    = 30;
  localparam int MEM_TO_REG_BIT = 29;
  localparam int REG_WRITE_BIT  = 28;
  localparam int RC_MSB         = 27;
  localparam int RC_LSB         = 24;
  localparam int QA_MSB         = 23;
  localparam int QA_LSB         = 0;

  localparam logic [1:0]        HALT_OP_TYPE = 2'b11;
  localparam logic [3:0]        HALT_OP_CODE = 4'hF;
  localparam logic [WORD_W-1:0] BUBBLE_WORD  = '0;

  typedef struct packed {
    logic [1:0]               op_type;
    logic [3:0]               op_code;
    logic                     mem_to_reg;
    logic                     reg_write;
    logic [WB_REG_ADDR_W-1:0] rc;
    logic [WB_DATA_W-1:0]     qa;
  } mem_wb_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

  function automatic logic is_halt_word(input mem_wb_t w);
    return (w.op_type == HALT_OP_TYPE) && (w.op_code == HALT_OP_CODE);
  endfunction

endpackage

// File: rtl/wb_forward_hist.sv
// Slot-1 bypass history: holds the previously retired writeback for decode.
// Loads on the edge after the write, holds while load is low; rst clears it.
module wb_forward_hist #(
  parameter int DATA_W     = 24,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  src_valid,
  input  logic [REG_ADDR_W-1:0] src_rc,
  input  logic [DATA_W-1:0]     src_data,
  output logic                  hist_valid,
  output logic [REG_ADDR_W-1:0] hist_rc,
  output logic [DATA_W-1:0]     hist_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= 1'b0;
      hist_rc    <= '0;
      hist_data  <= '0;
    end else if (load) begin
      hist_valid <= src_valid;
      hist_rc    <= src_rc;
      hist_data  <= src_data;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback: result select, regfile write port, two-deep bypass history and
// RUN/HALTED control; en=0 stalls all state. WB_RETIRE_COUNT_EN adds retireCount.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W
`ifdef WB_RETIRE_COUNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WORD_W-1:0]     bufferOut,
  input  logic [DATA_W-1:0]     aluResult,
  output logic                  regWriteEn,
  output logic [REG_ADDR_W-1:0] regWriteAddr,
  output logic [DATA_W-1:0]     regWriteData,
  output logic                  fwdValid0,
  output logic [REG_ADDR_W-1:0] fwdRc0,
  output logic [DATA_W-1:0]     fwdData0,
  output logic                  fwdValid1,
  output logic [REG_ADDR_W-1:0] fwdRc1,
  output logic [DATA_W-1:0]     fwdData1,
  output logic                  halted
`ifdef WB_RETIRE_COUNT_EN
  , output logic [CNT_W-1:0]    retireCount
`endif
);

  mem_wb_t     word;
  wb_state_t   state;
  wb_state_t   state_nxt;
  logic        is_halt;
  logic        is_bubble;
  logic        running;
  logic        advance;
  logic        wants_write;
  logic [DATA_W-1:0] write_data;

  assign word        = mem_wb_t'(bufferOut);
  assign is_halt     = is_halt_word(word);
  assign is_bubble   = (bufferOut == BUBBLE_WORD);
  assign running     = (state == RUN);
  assign advance     = en & running;
  assign write_data  = word.mem_to_reg ? word.qa : aluResult;
  // Valid even while stalled: the held word is still the youngest producer.
  assign wants_write = word.reg_write & ~is_halt & running;

  assign regWriteEn   = en & wants_write;
  assign regWriteAddr = word.rc;
  assign regWriteData = write_data;

  assign fwdValid0 = wants_write;
  assign fwdRc0    = word.rc;
  assign fwdData0  = write_data;

  assign halted = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // HALTED is sticky; only rst leaves it.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (en && is_halt) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  wb_forward_hist #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .load       (advance),
    .src_valid  (wants_write),
    .src_rc     (word.rc),
    .src_data   (write_data),
    .hist_valid (fwdValid1),
    .hist_rc    (fwdRc1),
    .hist_data  (fwdData1)
  );

`ifdef WB_RETIRE_COUNT_EN
  // Halt words retire too; bubbles never do.
  always_ff @(posedge clk) begin
    if (rst) begin
      retireCount <= '0;
    end else if (advance && !is_bubble) begin
      retireCount <= retireCount + 1'b1;
    end
  end
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage: consumes the 36-bit MEM/WB word produced by the memory stage, selects the result (memory read data or ALU result), drives the register-file write port, and publishes a two-deep forwarding history for decode. A RUN/HALTED state machine retires the halt instruction and freezes architectural writes until reset. An optional retired-instruction counter supports bring-up and performance checks.

## Interface
- DATA_W, 24, data and register width
- REG_ADDR_W, 4, register index width
- CNT_W, 32, retired-instruction counter width (used only with WB_RETIRE_COUNT_EN)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  pipeline advance; 0 = stall, MEM/WB word held upstream
- bufferOut  input  36  MEM/WB word {opType[35:34], opCode[33:30], memToReg[29], regWrite[28], Rc[27:24], qa[23:0]}
- aluResult  input  DATA_W  ALU result aligned with bufferOut (parallel MEM/WB register)
- regWriteEn  output  1  register-file write enable
- regWriteAddr  output  REG_ADDR_W  register-file write index (= Rc)
- regWriteData  output  DATA_W  register-file write data
- fwdValid0, fwdRc0, fwdData0  output  1/REG_ADDR_W/DATA_W  current-cycle writeback (bypass slot 0)
- fwdValid1, fwdRc1, fwdData1  output  1/REG_ADDR_W/DATA_W  previous retired writeback (bypass slot 1)
- halted  output  1  processor halted
- retireCount  output  CNT_W  retired non-bubble words (only with WB_RETIRE_COUNT_EN)

## Operation
- Field decode is combinational from bufferOut; writeData = memToReg ? qa : aluResult.
- Bubble: bufferOut == 36'h0 (MEM/WB reset/flush value). Bubbles never write, never retire.
- Halt: opType == 2'b11 and opCode == 4'hF. A halt word never writes, regardless of regWrite.
- States: RUN (reset), HALTED.
  - RUN -> HALTED at the rising edge where en=1 and the word is a halt.
  - HALTED -> RUN only on rst. No other exit.
- regWriteEn = en & regWrite & ~isHalt & (state==RUN). regWriteAddr = Rc, regWriteData = writeData (driven unconditionally).
- Slot 0: fwdValid0 = regWrite & ~isHalt & (state==RUN), not gated by en (held word is valid during stall); fwdRc0/fwdData0 = Rc/writeData.
- Slot 1: registered copy of slot 0, loaded on edges where en=1 and state==RUN; held otherwise.
- halted = (state==HALTED).
- Stall (en=0): no state change, no write, slot 1 and counter hold.

## Timing
- Register-file write: same cycle the word is present with en=1; regfile captures at that edge.
- Slot 1 valid one cycle after the corresponding write edge.
- halted asserts the cycle after the halt edge; the halt word's own cycle still shows halted=0.
- Reset values: state RUN, halted 0, fwdValid1 0, fwdRc1 0, fwdData1 0, retireCount 0. Combinational outputs follow bufferOut (all-zero word -> regWriteEn 0, fwdValid0 0).
- rst mid-operation or while HALTED: returns to RUN next cycle; rst dominates en and halt in the same cycle.
- Back-to-back writes to the same Rc: slot 0 holds newer, slot 1 older; decode gives slot 0 priority.

## Configuration
- WB_RETIRE_COUNT_EN defined: retireCount present; increments by 1 on each edge with en=1, state==RUN, word non-bubble (halt word counts); wraps modulo 2^CNT_W.
- Undefined: retireCount port and counter absent; all other behaviour identical.

## Structure
- Shared package (pipeline package): MEM/WB field bit positions, width constants (36-bit word, DATA_W, REG_ADDR_W), halt opType/opCode constants, state enum {RUN, HALTED}, bubble constant.
- One natural sub-module: wb_forward_hist (slot-1 register with load enable and synchronous clear). Field decode, result mux and state machine stay in the top.

## Test plan
- Reset, bufferOut=0 -> regWriteEn 0, halted 0, fwdValid0/1 0, retireCount 0.
- en=1, word {00,0001,0,1,R3,qa=0x000111}, aluResult=0xABCDEF -> regWriteEn 1, addr 3, data 0xABCDEF; next cycle fwdValid1 1, fwdRc1 3, fwdData1 0xABCDEF, retireCount 1.
- Same with memToReg=1 -> data 0x000111; en=0 for 3 cycles -> regWriteEn 0, fwdValid0 1, slot 1 and retireCount unchanged.
- Halt word {11,1111,0,1,R5,...} en=1 -> regWriteEn 0 that cycle, halted 1 next; subsequent write words -> regWriteEn 0, fwdValid0 0, retireCount frozen.
- rst while HALTED -> halted 0, retireCount 0, fwdValid1 0 next cycle; a write word then retires normally.
- Counter at 0xFFFFFFFF, one retire -> 0x00000000.
